screen_sequencer: RTL and testbench
===================================

Name: screen_sequencer

Overview:
- Top-level frame sequencer that sits downstream of display_game and arbitrates what reaches the VGA adapter.
- Clears the 160x120 screen, starts a game, and passes the game's pixel writes through while it runs.
- On game end, floods the screen with the game-over colour, holds it, then restarts or returns to idle.
- Also owns display_game's start handshake and counts completed games.

Parameters:
- SCR_W, 160, screen width in pixels; x range 0..SCR_W-1.
- SCR_H, 120, screen height in pixels; y range 0..SCR_H-1.
- BG_COLOUR, 3'b000, clear colour.
- GO_COLOUR, 3'b100, game-over fill colour.
- GO_HOLD, 1024, cycles the game-over screen is held (minimum 1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-high: asserted when 1, sampled on posedge clk.
- run  in  1  level request to play; sampled in IDLE and at end of OVER_HOLD.
- game_done  in  1  one-cycle done pulse from display_game.
- game_x  in  8  pixel x from display_game.
- game_y  in  7  pixel y from display_game.
- game_colour  in  3  pixel colour from display_game.
- game_plot  in  1  pixel write strobe from display_game.
- game_start  out  1  start pulse to display_game.
- vga_x  out  8  pixel x to VGA adapter.
- vga_y  out  7  pixel y to VGA adapter.
- vga_colour  out  3  pixel colour to VGA adapter.
- vga_plot  out  1  pixel write strobe to VGA adapter.
- busy  out  1  high in every state except IDLE.
- games_played  out  8  count of completed games.

Behaviour:
- Reset (rst_n=1 at a posedge):
  - state=IDLE; fill counters fx=0, fy=0; hold counter=0; games_played=0.
  - Outputs during and after reset until leaving IDLE: vga_x=0, vga_y=0, vga_colour=BG_COLOUR, vga_plot=0, game_start=0, busy=0.
  - Reset mid-fill or mid-play aborts immediately. display_game is reset by the same line.
- Output timing:
  - vga_* and game_start are combinational from state and counters (Moore).
  - In PLAY only, vga_* are a zero-latency pass-through of game_*.
- State IDLE: if run=1, go to CLEAR next cycle with fx=fy=0.
- State CLEAR:
  - Each cycle: vga_plot=1, vga_x=fx, vga_y=fy, vga_colour=BG_COLOUR.
  - fy increments each cycle. When fy=SCR_H-1, fy wraps to 0 and fx increments.
  - After (SCR_W-1, SCR_H-1) is plotted, go to START.
  - Exactly SCR_W*SCR_H plot cycles (19200 at defaults); first pixel is (0,0) in the first CLEAR cycle.
- State START: game_start=1 for exactly one cycle, vga_plot=0, then go to PLAY.
- State PLAY:
  - Pass-through of game_* to vga_*.
  - On game_done=1: games_played increments (255 wraps to 0), fx=fy=0, go to OVER_FILL next cycle.
  - run is ignored; there is no abort on run=0.
- State OVER_FILL: identical sweep to CLEAR using GO_COLOUR; then go to OVER_HOLD with hold=0.
- State OVER_HOLD:
  - vga_plot=0; hold increments each cycle.
  - When hold=GO_HOLD-1: if run=1 go to CLEAR (fx=fy=0), else go to IDLE.
- Ignored inputs:
  - game_done outside PLAY is ignored and does not count.
  - game_plot outside PLAY is dropped (vga_plot reflects only the sweep).
- Simultaneous events: game_done in the same cycle as game_plot in PLAY passes the plot through and still transitions.
- Width rules:
  - fx is 8 bits, fy is 7 bits, compared against SCR_W-1 and SCR_H-1 truncated to those widths.
  - hold counter is $clog2(GO_HOLD)+1 bits.

Decomposition:
- Shared package snake_pkg holds:
  - state enum seq_state_t {IDLE, CLEAR, START, PLAY, OVER_FILL, OVER_HOLD};
  - localparams SCR_W_DEF=160 and SCR_H_DEF=120;
  - colour constants COL_BLACK=3'b000 and COL_RED=3'b100, reused by display_game.
- One sub-module, screen_fill: a rectangle sweeper with a go/last handshake and colour input.
  - Instantiated once and reused by CLEAR and OVER_FILL; the sequencer muxes its colour.

Test Plan:
- Reset with run=1 held, then release -> first cycle after release: vga_plot=1 at (0,0), colour 000; exactly 19200 plot cycles; last plot at (159,119); then game_start=1 for exactly 1 cycle.
- In PLAY, drive game_x=20, game_y=15, game_colour=3'b010, game_plot=1 -> vga_* equal these values in the same cycle; game_plot=0 -> vga_plot=0.
- Pulse game_done in PLAY -> games_played 0->1; next 19200 cycles plot colour 100 over the full screen; then 1024 cycles with vga_plot=0; with run=1, CLEAR restarts at (0,0).
- Same as previous case but run=0 at end of OVER_HOLD -> state IDLE, busy=0; pulse game_done in IDLE -> games_played unchanged.
- Assert rst_n=1 at pixel (57,30) of CLEAR -> next cycle vga_plot=0, busy=0; release with run=1 -> sweep restarts at (0,0).
- Run 256 game cycles (small GO_HOLD=1 and small SCR_W/SCR_H for speed) -> games_played wraps to 0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the screen sequencer and display_game.
package snake_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START,
    PLAY,
    OVER_FILL,
    OVER_HOLD
  } seq_state_t;

  localparam int unsigned SCR_W_DEF = 160;
  localparam int unsigned SCR_H_DEF = 120;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned COL_W = 3;
  localparam int unsigned CNT_W = 8;

  localparam logic [COL_W-1:0] COL_BLACK = 3'b000;
  localparam logic [COL_W-1:0] COL_RED   = 3'b100;

endpackage

// File: rtl/screen_fill.sv
// Column-major rectangle sweeper: fy runs fastest, fx advances on each fy wrap.
module screen_fill
  import snake_pkg::*;
#(
  parameter int unsigned W = SCR_W_DEF,
  parameter int unsigned H = SCR_H_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             go,
  input  logic [COL_W-1:0] colour,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [COL_W-1:0] pix_colour,
  output logic             plot,
  output logic             last
);

  localparam logic [X_W-1:0] X_LAST = X_W'(W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(H - 1);

  logic [X_W-1:0] fx;
  logic [Y_W-1:0] fy;

  // Sweep position; wraps to (0,0) after the final pixel so the next sweep starts clean.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      fx <= '0;
      fy <= '0;
    end else if (go) begin
      if (fy == Y_LAST) begin
        fy <= '0;
        fx <= last ? '0 : fx + X_W'(1);
      end else begin
        fy <= fy + Y_W'(1);
      end
    end
  end

  assign last       = (fx == X_LAST) && (fy == Y_LAST);
  assign x          = fx;
  assign y          = fy;
  assign pix_colour = colour;
  assign plot       = go;

endmodule

// File: rtl/screen_sequencer.sv
// Frame sequencer between display_game and the VGA adapter: clear, play, game-over fill/hold.
module screen_sequencer
  import snake_pkg::*;
#(
  parameter int unsigned      SCR_W     = SCR_W_DEF,
  parameter int unsigned      SCR_H     = SCR_H_DEF,
  parameter logic [COL_W-1:0] BG_COLOUR = COL_BLACK,
  parameter logic [COL_W-1:0] GO_COLOUR = COL_RED,
  parameter int unsigned      GO_HOLD   = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             game_done,
  input  logic [X_W-1:0]   game_x,
  input  logic [Y_W-1:0]   game_y,
  input  logic [COL_W-1:0] game_colour,
  input  logic             game_plot,
  output logic             game_start,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [COL_W-1:0] vga_colour,
  output logic             vga_plot,
  output logic             busy,
  output logic [CNT_W-1:0] games_played
);

  localparam int unsigned          HOLD_W    = $clog2(GO_HOLD) + 1;
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(GO_HOLD - 1);

  seq_state_t        state;
  seq_state_t        state_next;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_next;
  logic [CNT_W-1:0]  games;
  logic [CNT_W-1:0]  games_next;

  logic              fill_restart;
  logic              fill_go;
  logic [COL_W-1:0]  fill_colour;
  logic [X_W-1:0]    fill_x;
  logic [Y_W-1:0]    fill_y;
  logic [COL_W-1:0]  fill_pix_colour;
  logic              fill_plot;
  logic              fill_last;

  screen_fill #(
    .W(SCR_W),
    .H(SCR_H)
  ) u_fill (
    .clk        (clk),
    .rst        (rst_n),
    .restart    (fill_restart),
    .go         (fill_go),
    .colour     (fill_colour),
    .x          (fill_x),
    .y          (fill_y),
    .pix_colour (fill_pix_colour),
    .plot       (fill_plot),
    .last       (fill_last)
  );

  // State, hold timer and game counter registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      hold  <= '0;
      games <= '0;
    end else begin
      state <= state_next;
      hold  <= hold_next;
      games <= games_next;
    end
  end

  // Next-state logic and Moore outputs; only PLAY forwards the game's pixel stream.
  always_comb begin
    state_next   = state;
    hold_next    = hold;
    games_next   = games;
    fill_restart = 1'b0;
    fill_go      = 1'b0;
    fill_colour  = BG_COLOUR;
    game_start   = 1'b0;
    vga_x        = '0;
    vga_y        = '0;
    vga_colour   = BG_COLOUR;
    vga_plot     = 1'b0;

    case (state)
      IDLE: begin
        if (run) begin
          fill_restart = 1'b1;
          state_next   = CLEAR;
        end
      end
      CLEAR: begin
        fill_go    = 1'b1;
        vga_x      = fill_x;
        vga_y      = fill_y;
        vga_colour = fill_pix_colour;
        vga_plot   = fill_plot;
        if (fill_last) state_next = START;
      end
      START: begin
        game_start = 1'b1;
        state_next = PLAY;
      end
      PLAY: begin
        vga_x      = game_x;
        vga_y      = game_y;
        vga_colour = game_colour;
        vga_plot   = game_plot;
        if (game_done) begin
          games_next   = games + CNT_W'(1);
          fill_restart = 1'b1;
          state_next   = OVER_FILL;
        end
      end
      OVER_FILL: begin
        fill_go     = 1'b1;
        fill_colour = GO_COLOUR;
        vga_x       = fill_x;
        vga_y       = fill_y;
        vga_colour  = fill_pix_colour;
        vga_plot    = fill_plot;
        if (fill_last) begin
          hold_next  = '0;
          state_next = OVER_HOLD;
        end
      end
      OVER_HOLD: begin
        hold_next = hold + HOLD_W'(1);
        if (hold == HOLD_LAST) begin
          hold_next = '0;
          if (run) begin
            fill_restart = 1'b1;
            state_next   = CLEAR;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign games_played = games;

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer using a reduced screen for runtime.
module tb_screen_sequencer;

  localparam int unsigned W    = 10;
  localparam int unsigned H    = 6;
  localparam int unsigned GH   = 5;
  localparam int unsigned WH   = W * H;
  localparam int unsigned NONE = 32'hFFFF_FFFF;
  localparam logic [2:0]  BG   = 3'b000;
  localparam logic [2:0]  GO   = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       game_done;
  logic [7:0] game_x;
  logic [6:0] game_y;
  logic [2:0] game_colour;
  logic       game_plot;
  logic       game_start;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic [7:0] games_played;

  screen_sequencer #(
    .SCR_W     (W),
    .SCR_H     (H),
    .BG_COLOUR (BG),
    .GO_COLOUR (GO),
    .GO_HOLD   (GH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .game_done    (game_done),
    .game_x       (game_x),
    .game_y       (game_y),
    .game_colour  (game_colour),
    .game_plot    (game_plot),
    .game_start   (game_start),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .busy         (busy),
    .games_played (games_played)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned x;
    int unsigned y;
    int unsigned col;
    int unsigned cyc;
  } px_t;

  px_t         exp_q[$];
  px_t         mon_e;
  int unsigned cyc       = 0;
  int unsigned exp_start = NONE;
  int unsigned games_exp = 0;
  logic        exp_busy  = 1'b0;
  int          checks    = 0;
  int          errors    = 0;

  // Cycle index: cycle n is the interval following the n-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    game_done   = 1'b0;
    game_plot   = 1'b0;
    game_x      = '0;
    game_y      = '0;
    game_colour = '0;
  endtask

  task automatic junk();
    game_done   = 1'($urandom);
    game_plot   = 1'($urandom);
    game_x      = 8'($urandom);
    game_y      = 7'($urandom);
    game_colour = 3'($urandom);
  endtask

  // Every pixel of the screen, column by column, one per cycle from 'start'.
  task automatic push_sweep(input int unsigned start, input int unsigned col);
    for (int unsigned x = 0; x < W; x++)
      for (int unsigned y = 0; y < H; y++)
        exp_q.push_back('{x: x, y: y, col: col, cyc: start + x * H + y});
  endtask

  task automatic idle_until(input int unsigned n);
    while (cyc < n) begin
      junk();
      tick();
    end
    quiet();
  endtask

  task automatic check_idle_outputs();
    junk();
    @(negedge clk);
    chk("idle_vga_x", vga_x, 0);
    chk("idle_vga_y", vga_y, 0);
    chk("idle_vga_colour", vga_colour, BG);
    chk("idle_vga_plot", vga_plot, 0);
    @(posedge clk);
    #1;
    quiet();
  endtask

  // Leave reset / idle with run high; clear sweep starts the next cycle.
  task automatic launch();
    rst_n = 1'b0;
    run   = 1'b1;
    push_sweep(cyc + 1, BG);
    exp_start = cyc + 1 + WH;
    tick();
    exp_busy = 1'b1;
  endtask

  task automatic play_game(input bit run_after, input int unsigned nplay, input bit directed);
    int unsigned d;
    idle_until(exp_start + 1);
    for (int unsigned i = 0; i < nplay; i++) begin
      game_x      = 8'($urandom);
      game_y      = 7'($urandom);
      game_colour = 3'($urandom);
      game_plot   = 1'($urandom);
      if (directed && i == 0) begin
        game_x = 8'd20; game_y = 7'd15; game_colour = 3'b010; game_plot = 1'b1;
      end
      if (directed && i == 1) game_plot = 1'b0;
      if (game_plot) exp_q.push_back('{x: game_x, y: game_y, col: game_colour, cyc: cyc});
      tick();
    end
    game_x      = 8'($urandom);
    game_y      = 7'($urandom);
    game_colour = 3'($urandom);
    game_plot   = 1'($urandom);
    game_done   = 1'b1;
    if (game_plot) exp_q.push_back('{x: game_x, y: game_y, col: game_colour, cyc: cyc});
    d = cyc;
    push_sweep(d + 1, GO);
    run = run_after;
    if (run_after) begin
      push_sweep(d + 1 + WH + GH, BG);
      exp_start = d + 1 + WH + GH + WH;
    end else begin
      exp_start = NONE;
    end
    tick();
    quiet();
    games_exp = games_exp + 1;
    idle_until(d + 1 + WH + GH);
    if (!run_after) exp_busy = 1'b0;
  endtask

  // Scoreboard monitor: pops expected pixels as the DUT plots; checks strobes every cycle.
  always @(negedge clk) begin
    if (cyc != 0) begin
      if (vga_plot) begin
        if (exp_q.size() == 0) begin
          chk("stray_plot", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("plot_cycle", cyc, mon_e.cyc);
          chk("plot_x", vga_x, mon_e.x);
          chk("plot_y", vga_y, mon_e.y);
          chk("plot_colour", vga_colour, mon_e.col);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        chk("missing_plot", 0, 1);
        mon_e = exp_q.pop_front();
      end
      chk("game_start", game_start, (cyc == exp_start) ? 1 : 0);
      chk("busy", busy, exp_busy);
      chk("games_played", games_played, games_exp % 256);
    end
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s;
    rst_n = 1'b1;
    run   = 1'b1;
    quiet();
    tick();
    tick();
    check_idle_outputs();

    launch();
    play_game(1'b1, 2, 1'b1);
    play_game(1'b0, 1 + $urandom % 4, 1'b0);

    // game_done in IDLE must not count
    for (int i = 0; i < 6; i++) begin
      game_done = 1'b1;
      game_plot = 1'($urandom);
      tick();
    end
    quiet();
    check_idle_outputs();

    // Reset in the middle of a clear sweep
    launch();
    s = cyc;
    idle_until(s + 5 * H + 3);
    rst_n = 1'b1;
    while (exp_q.size() != 0 && exp_q[exp_q.size() - 1].cyc > cyc) void'(exp_q.pop_back());
    tick();
    exp_busy  = 1'b0;
    games_exp = 0;
    exp_start = NONE;
    check_idle_outputs();
    launch();

    // Enough back-to-back games to wrap the counter
    for (int g = 0; g < 256; g++)
      play_game((g != 255), 1 + $urandom % 3, 1'b0);

    idle_until(cyc + 4);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
